// File: rtl/abcd_seq_pkg.sv
// rtl/abcd_seq_pkg.sv - shared state/step encodings and step constants for the ABCD sequencer
package abcd_seq_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    STEP_0,
    STEP_1,
    STEP_2,
    STEP_3
  } step_e;

  typedef enum logic [1:0] {
    SEL_A,
    SEL_B,
    SEL_C,
    SEL_D
  } reg_sel_e;

  localparam int SUB_K = 3;
  localparam int ADD_K = 10;

endpackage

// File: rtl/abcd_step_alu.sv
// rtl/abcd_step_alu.sv - combinational step datapath: picks the target register and its next value
module abcd_step_alu
  import abcd_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  step_e            step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  output reg_sel_e         sel_o,
  output logic [WIDTH-1:0] value_o
);

  always_comb begin
    sel_o   = SEL_A;
    value_o = b_i + c_i;
    case (step_i)
      STEP_0: begin
        sel_o   = SEL_A;
        value_o = b_i + c_i;
      end
      STEP_1: begin
        sel_o   = SEL_D;
        value_o = a_i - WIDTH'(SUB_K);
      end
      STEP_2: begin
        sel_o   = SEL_B;
        value_o = d_i + WIDTH'(ADD_K);
      end
      STEP_3: begin
        sel_o   = SEL_C;
        value_o = c_i + WIDTH'(1);
      end
      default: begin
        sel_o   = SEL_A;
        value_o = b_i + c_i;
      end
    endcase
  end

endmodule

// File: rtl/abcd_sequencer.sv
// rtl/abcd_sequencer.sv - timed four-step a/b/c/d sequencer; ABCD_SEQ_ABORT_EN adds an abort input
module abcd_sequencer
  import abcd_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ITER        = 4,
  parameter int STEP_CYCLES = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
`ifdef ABCD_SEQ_ABORT_EN
  input  logic                       abort,
`endif
  input  logic [WIDTH-1:0]           a_init,
  input  logic [WIDTH-1:0]           b_init,
  input  logic [WIDTH-1:0]           c_init,
  input  logic [WIDTH-1:0]           d_init,
  output logic [WIDTH-1:0]           a,
  output logic [WIDTH-1:0]           b,
  output logic [WIDTH-1:0]           c,
  output logic [WIDTH-1:0]           d,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(ITER+1)-1:0]  iter_cnt
);

  localparam int CW = $clog2(ITER + 1);
  localparam int DW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] ITER_LAST  = CW'(ITER);
  localparam logic [DW-1:0] DELAY_LAST = DW'(STEP_CYCLES - 1);

  state_e           state_q, state_d;
  step_e            step_q, step_d;
  logic [DW-1:0]    delay_q, delay_d;
  logic [CW-1:0]    iter_q, iter_d, iter_next;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             done_q, done_d;
  logic             abort_w;
  reg_sel_e         alu_sel;
  logic [WIDTH-1:0] alu_val;

`ifdef ABCD_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  abcd_step_alu #(.WIDTH(WIDTH)) u_alu (
    .step_i  (step_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .c_i     (c_q),
    .d_i     (d_q),
    .sel_o   (alu_sel),
    .value_o (alu_val)
  );

  assign iter_next = iter_q + 1'b1;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    delay_d = delay_q;
    iter_d  = iter_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          step_d  = STEP_0;
          delay_d = '0;
          iter_d  = '0;
          a_d     = a_init;
          b_d     = b_init;
          c_d     = c_init;
          d_d     = d_init;
        end
      end
      ST_RUN: begin
        // Abort leaves the datapath frozen mid-run and never raises done.
        if (abort_w) begin
          state_d = ST_IDLE;
        end else if (delay_q == DELAY_LAST) begin
          delay_d = '0;
          step_d  = step_e'(step_q + 2'd1);
          case (alu_sel)
            SEL_A:   a_d = alu_val;
            SEL_B:   b_d = alu_val;
            SEL_C:   c_d = alu_val;
            SEL_D:   d_d = alu_val;
            default: a_d = a_q;
          endcase
          if (step_q == STEP_3) begin
            iter_d = iter_next;
            if (iter_next == ITER_LAST) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          delay_d = delay_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_0;
      delay_q <= '0;
      iter_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      delay_q <= delay_d;
      iter_q  <= iter_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign c        = c_q;
  assign d        = d_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_abcd_sequencer.sv
// tb/tb_abcd_sequencer.sv - self-checking bench for abcd_sequencer across three parameter sets
module tb_abcd_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // DUT0: defaults
  logic        start0 = 1'b0;
  logic [31:0] ai0 = '0, bi0 = '0, ci0 = '0, di0 = '0;
  logic [31:0] a0, b0, c0, d0;
  logic        busy0, done0;
  logic [2:0]  iter0;
`ifdef ABCD_SEQ_ABORT_EN
  logic        abort0 = 1'b0;
  logic        abort1 = 1'b0;
  logic        abort2 = 1'b0;
`endif

  abcd_sequencer dut0 (
    .clk(clk), .rst(rst), .start(start0),
`ifdef ABCD_SEQ_ABORT_EN
    .abort(abort0),
`endif
    .a_init(ai0), .b_init(bi0), .c_init(ci0), .d_init(di0),
    .a(a0), .b(b0), .c(c0), .d(d0),
    .busy(busy0), .done(done0), .iter_cnt(iter0)
  );

  // DUT1: ITER=2, STEP_CYCLES=1
  logic        start1 = 1'b0;
  logic [31:0] a1, b1, c1, d1;
  logic        busy1, done1;
  logic [1:0]  iter1;

  abcd_sequencer #(.WIDTH(32), .ITER(2), .STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
`ifdef ABCD_SEQ_ABORT_EN
    .abort(abort1),
`endif
    .a_init(ai0), .b_init(bi0), .c_init(ci0), .d_init(di0),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .iter_cnt(iter1)
  );

  // DUT2: WIDTH=8, ITER=1, STEP_CYCLES=1
  logic       start2 = 1'b0;
  logic [7:0] ai2 = '0, bi2 = '0, ci2 = '0, di2 = '0;
  logic [7:0] a2, b2, c2, d2;
  logic       busy2, done2;
  logic [0:0] iter2;

  abcd_sequencer #(.WIDTH(8), .ITER(1), .STEP_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
`ifdef ABCD_SEQ_ABORT_EN
    .abort(abort2),
`endif
    .a_init(ai2), .b_init(bi2), .c_init(ci2), .d_init(di2),
    .a(a2), .b(b2), .c(c2), .d(d2),
    .busy(busy2), .done(done2), .iter_cnt(iter2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: apply nsteps of the a/d/b/c recurrence, modulo 2^width.
  function automatic logic [127:0] model(input logic [31:0] ai, bi, ci, di,
                                         input int nsteps, input int width);
    longint unsigned m, ra, rb, rc, rd;
    m  = (width >= 32) ? 64'hFFFF_FFFF : ((64'd1 << width) - 1);
    ra = ai & m; rb = bi & m; rc = ci & m; rd = di & m;
    for (int k = 0; k < nsteps; k++) begin
      case (k % 4)
        0: ra = (rb + rc) & m;
        1: rd = (ra - 3) & m;
        2: rb = (rd + 10) & m;
        default: rc = (rc + 1) & m;
      endcase
    end
    return {ra[31:0], rb[31:0], rc[31:0], rd[31:0]};
  endfunction

  task automatic run_dut0(input logic [31:0] ai, bi, ci, di, input int pulse_at, input string tag);
    logic [127:0] exp;
    ai0 = ai; bi0 = bi; ci0 = ci; di0 = di;
    start0 = 1'b1;
    tick(1);
    for (int n = 1; n <= 80; n++) begin
      start0 = (pulse_at > 0 && n == pulse_at + 1);
      tick(1);
      exp = model(ai, bi, ci, di, n / 5, 32);
      total_cnt++;
      if ({a0, b0, c0, d0} !== exp)
        $display("FAIL %s regs edge %0d: got %h want %h", tag, n, {a0, b0, c0, d0}, exp);
      else pass_cnt++;
      total_cnt++;
      if (busy0 !== (n < 80)) $display("FAIL %s busy edge %0d: got %b want %b", tag, n, busy0, n < 80);
      else pass_cnt++;
      total_cnt++;
      if (done0 !== (n == 80)) $display("FAIL %s done edge %0d: got %b want %b", tag, n, done0, n == 80);
      else pass_cnt++;
      total_cnt++;
      if (iter0 !== 3'(n / 20)) $display("FAIL %s iter edge %0d: got %0d want %0d", tag, n, iter0, n / 20);
      else pass_cnt++;
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b1; ai0 = 32'd9; bi0 = 32'd9; ci0 = 32'd9; di0 = 32'd9;
    tick(2);
    total_cnt++;
    if ({a0, b0, c0, d0, busy0, done0, iter0} !== '0)
      $display("FAIL reset_state: got %h/%b/%b/%0d want 0", {a0, b0, c0, d0}, busy0, done0, iter0);
    else pass_cnt++;
    rst = 1'b0;
    tick(1);
    total_cnt++;
    if (busy0 !== 1'b1 || a0 !== 32'd9) $display("FAIL first_start: got busy %b a %0d want 1/9", busy0, a0);
    else pass_cnt++;
    start0 = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reference();
    run_dut0(32'd30, 32'd20, 32'd15, 32'd5, 0, "ref");
    total_cnt++;
    if ({a0, b0, c0, d0} !== {32'd107, 32'd114, 32'd19, 32'd104})
      $display("FAIL ref_final: got %0d/%0d/%0d/%0d want 107/114/19/104", a0, b0, c0, d0);
    else pass_cnt++;
    tick(3);
    total_cnt++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || iter0 !== 3'd4 || a0 !== 32'd107)
      $display("FAIL ref_idle_hold: got done %b busy %b iter %0d a %0d want 0/0/4/107", done0, busy0, iter0, a0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++)
      run_dut0($urandom, $urandom, $urandom, $urandom, (r == 2) ? int'($urandom_range(1, 78)) : 0, "rand");
    tick(1);
  endtask

  task automatic test_busy_start();
    run_dut0(32'd30, 32'd20, 32'd15, 32'd5, 10, "busy_start");
    tick(1);
  endtask

  task automatic test_back_to_back();
    ai0 = 32'd30; bi0 = 32'd20; ci0 = 32'd15; di0 = 32'd5;
    start0 = 1'b1;
    tick(81);
    total_cnt++;
    if (done0 !== 1'b1 || busy0 !== 1'b0) $display("FAIL b2b_done1: got done %b busy %b want 1/0", done0, busy0);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (busy0 !== 1'b1 || done0 !== 1'b0 || a0 !== 32'd30 || iter0 !== 3'd0)
      $display("FAIL b2b_reload: got busy %b done %b a %0d iter %0d want 1/0/30/0", busy0, done0, a0, iter0);
    else pass_cnt++;
    tick(79);
    start0 = 1'b0;
    tick(1);
    total_cnt++;
    if (done0 !== 1'b1 || {a0, b0, c0, d0} !== {32'd107, 32'd114, 32'd19, 32'd104})
      $display("FAIL b2b_done2: got done %b regs %0d/%0d/%0d/%0d want 1 107/114/19/104", done0, a0, b0, c0, d0);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) $display("FAIL b2b_stop: got busy %b done %b want 0/0", busy0, done0);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int dones;
    dones = 0;
    ai0 = 32'd30; bi0 = 32'd20; ci0 = 32'd15; di0 = 32'd5;
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    for (int n = 0; n < 37; n++) begin
      tick(1);
      if (done0) dones++;
    end
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({a0, b0, c0, d0, busy0, done0, iter0} !== '0)
      $display("FAIL async_reset: got %h/%b/%b/%0d want 0", {a0, b0, c0, d0}, busy0, done0, iter0);
    else pass_cnt++;
    tick(2);
    if (done0) dones++;
    total_cnt++;
    if (dones !== 0) $display("FAIL reset_no_done: got %0d done pulses want 0", dones);
    else pass_cnt++;
    rst = 1'b0;
    run_dut0(32'd30, 32'd20, 32'd15, 32'd5, 0, "after_reset");
    tick(1);
  endtask

  task automatic test_short();
    logic [127:0] exp;
    logic [31:0] ra, rb, rc, rd;
    for (int r = 0; r < 3; r++) begin
      ra = (r == 0) ? 32'd30 : $urandom; rb = (r == 0) ? 32'd20 : $urandom;
      rc = (r == 0) ? 32'd15 : $urandom; rd = (r == 0) ? 32'd5 : $urandom;
      ai0 = ra; bi0 = rb; ci0 = rc; di0 = rd;
      start1 = 1'b1;
      tick(1);
      start1 = 1'b0;
      for (int n = 1; n <= 8; n++) begin
        tick(1);
        exp = model(ra, rb, rc, rd, n, 32);
        total_cnt++;
        if ({a1, b1, c1, d1} !== exp || done1 !== (n == 8) || busy1 !== (n < 8))
          $display("FAIL short edge %0d: got %h d%b b%b want %h d%b b%b", n, {a1, b1, c1, d1}, done1, busy1, exp, n == 8, n < 8);
        else pass_cnt++;
      end
      total_cnt++;
      if (r == 0 && {a1, b1, c1, d1} !== {32'd58, 32'd65, 32'd17, 32'd55})
        $display("FAIL short_final: got %0d/%0d/%0d/%0d want 58/65/17/55", a1, b1, c1, d1);
      else if (iter1 !== 2'd2) $display("FAIL short_iter: got %0d want 2", iter1);
      else pass_cnt++;
    end
    tick(1);
  endtask

  task automatic test_wrap();
    logic [127:0] exp;
    logic [7:0] ra, rb, rc, rd;
    for (int r = 0; r < 3; r++) begin
      ra = (r == 0) ? 8'd0 : 8'($urandom); rb = (r == 0) ? 8'd0 : 8'($urandom);
      rc = (r == 0) ? 8'd0 : 8'($urandom); rd = (r == 0) ? 8'd0 : 8'($urandom);
      ai2 = ra; bi2 = rb; ci2 = rc; di2 = rd;
      start2 = 1'b1;
      tick(1);
      start2 = 1'b0;
      tick(4);
      exp = model(32'(ra), 32'(rb), 32'(rc), 32'(rd), 4, 8);
      total_cnt++;
      if ({24'd0, a2, 24'd0, b2, 24'd0, c2, 24'd0, d2} !== exp || done2 !== 1'b1 || iter2 !== 1'b1)
        $display("FAIL wrap run %0d: got %0d/%0d/%0d/%0d done %b want %h done 1", r, a2, b2, c2, d2, done2, exp);
      else pass_cnt++;
      total_cnt++;
      if (r == 0 && {a2, b2, c2, d2} !== {8'd0, 8'd7, 8'd1, 8'd253})
        $display("FAIL wrap_zero: got %0d/%0d/%0d/%0d want 0/7/1/253", a2, b2, c2, d2);
      else pass_cnt++;
      tick(1);
    end
  endtask

`ifdef ABCD_SEQ_ABORT_EN
  task automatic test_abort();
    int dones;
    dones = 0;
    ai0 = 32'd30; bi0 = 32'd20; ci0 = 32'd15; di0 = 32'd5;
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    tick(25);
    abort0 = 1'b1;
    tick(1);
    abort0 = 1'b0;
    total_cnt++;
    if (busy0 !== 1'b0 || a0 !== 32'd58) $display("FAIL abort_stop: got busy %b a %0d want 0/58", busy0, a0);
    else pass_cnt++;
    for (int n = 0; n < 60; n++) begin
      tick(1);
      if (done0) dones++;
    end
    total_cnt++;
    if (dones !== 0 || {a0, b0, c0, d0} !== model(32'd30, 32'd20, 32'd15, 32'd5, 5, 32))
      $display("FAIL abort_hold: got %0d dones regs %h want 0 held", dones, {a0, b0, c0, d0});
    else pass_cnt++;
    abort0 = 1'b1; start0 = 1'b1;
    tick(1);
    abort0 = 1'b0; start0 = 1'b0;
    total_cnt++;
    if (busy0 !== 1'b1 || a0 !== 32'd30) $display("FAIL abort_idle_start: got busy %b a %0d want 1/30", busy0, a0);
    else pass_cnt++;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_reference();
    test_random();
    test_busy_start();
    test_back_to_back();
    test_mid_reset();
    test_short();
    test_wrap();
`ifdef ABCD_SEQ_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/abcd_sequencer.md
ABCD_SEQUENCER -- requirements
Module: abcd_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data register width.
REQ-002 SHALL have parameter ITER, default 4, iterations per run (>=1).
REQ-003 SHALL have parameter STEP_CYCLES, default 5, clock cycles per step (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-007 SHALL have ports a_init, b_init, c_init, d_init  input  WIDTH each  initial values, loaded on accepted start.
REQ-008 SHALL have ports a, b, c, d  output  WIDTH each  registered datapath values.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port iter_cnt  output  $clog2(ITER+1)  completed iterations in the current or last run.

Function
REQ-012 SHALL implement states IDLE and RUN, with a step index 0..3 and a delay counter 0..STEP_CYCLES-1.
REQ-013 SHALL, on an edge with IDLE and start=1, load a..d from the init inputs, clear iter_cnt, step and delay, set busy, and enter RUN.
REQ-014 SHALL, in RUN, increment delay each edge; on the edge where delay==STEP_CYCLES-1, clear delay and perform the current step.
REQ-015 SHALL perform step 0: a<=b+c; step 1: d<=a-3; step 2: b<=d+10; step 3: c<=c+1 and iter_cnt<=iter_cnt+1; each step reads values written by earlier steps.
REQ-016 SHALL compute all arithmetic modulo 2^WIDTH (two's complement wrap), with no saturation or flags.
REQ-017 SHALL, on the step-3 edge where iter_cnt reaches ITER, return to IDLE, clear busy, and assert done for exactly one cycle.
REQ-018 SHALL complete a run exactly 4*ITER*STEP_CYCLES edges after the load edge.
REQ-019 SHALL ignore start while busy; a..d SHALL hold their values in IDLE.
REQ-020 SHALL, when start=1 in the cycle done is high, accept it as a new run (back-to-back).

Reset
REQ-021 SHALL, on rst=1 at any time including mid-run, immediately force state IDLE, a=b=c=d=0, busy=0, done=0, iter_cnt=0, step=0, delay=0.
REQ-022 SHALL ignore start while rst=1; the first start is accepted on the first edge after rst deasserts.

Configuration
REQ-023 SHALL, with macro ABCD_SEQ_ABORT_EN defined, add input abort (1 bit): abort=1 in RUN returns to IDLE on that edge, holds a..d, clears busy, and suppresses done; abort is ignored in IDLE, and start wins.
REQ-024 SHALL, without ABCD_SEQ_ABORT_EN, have no abort port, and every accepted run SHALL complete.

Structure
REQ-025 SHALL place the state enum, step enum, and constants SUB_K=3, ADD_K=10 in package abcd_seq_pkg.
REQ-026 SHALL use one combinational sub-module, abcd_step_alu, which takes the step index and a..d and returns the target register select and next value; sequencing SHALL stay in abcd_sequencer.

Verification
REQ-027 SHALL cover defaults, init 30/20/15/5, start pulse: at load+20 edges, a=35, b=42, c=16, d=32; at load+80 edges, a=107, b=114, c=19, d=104, done pulses once, iter_cnt=4, busy falls.
REQ-028 SHALL cover ITER=2, STEP_CYCLES=1, the same init: after 4 edges, 35/42/16/32; after 8 edges, a=58, b=65, c=17, d=55 with done.
REQ-029 SHALL cover WIDTH=8, ITER=1, STEP_CYCLES=1, init 0/0/0/0: final a=0, d=253, b=7, c=1 (wrap).
REQ-030 SHALL cover rst asserted at load+37 edges: all outputs 0 asynchronously, no done; a new start after release reproduces the REQ-027 results.
REQ-031 SHALL cover start pulsed while busy at load+10: ignored, with the REQ-027 results unchanged; start held high through done: a second run begins with no idle gap.
REQ-032 SHALL cover, with ABCD_SEQ_ABORT_EN, abort at load+25: busy=0 next cycle, a=58 held, done never asserted.
